// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks destinations of in-flight instructions across DEPTH
// post-ID stages and derives the load-use stall, forwarding selects and a stall counter.
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_wrt_reg,
  input  logic [REG_AW-1:0] id_wrt_addr,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DEPTH:1]    v_q, v_d;
  logic [DEPTH:1]    wr_q, wr_d;
  logic [DEPTH:1]    ld_q, ld_d;
  logic [REG_AW-1:0] addr_q [1:DEPTH];
  logic [REG_AW-1:0] addr_d [1:DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [DEPTH:1]    match_a;
  logic [DEPTH:1]    match_b;
  logic              load_hit;

  // Per-slot source match; register 0 is hard-wired and never produces a hazard.
  always_comb begin
    match_a = {DEPTH{1'b0}};
    match_b = {DEPTH{1'b0}};
    for (int k = 1; k <= DEPTH; k++) begin
      match_a[k] = v_q[k] & wr_q[k] & (addr_q[k] == id_rs) & (id_rs != {REG_AW{1'b0}})
                   & id_uses_rs & id_valid;
      match_b[k] = v_q[k] & wr_q[k] & (addr_q[k] == id_rt) & (id_rt != {REG_AW{1'b0}})
                   & id_uses_rt & id_valid;
    end
  end

  // Forward selects (youngest producer wins, so scan oldest-first and let younger overwrite)
  // and the load-use stall from slots whose load data is not yet available.
  always_comb begin
    fwd_a_sel = {SEL_W{1'b0}};
    fwd_b_sel = {SEL_W{1'b0}};
    load_hit  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      fwd_a_sel = match_a[k] ? SEL_W'(k) : fwd_a_sel;
      fwd_b_sel = match_b[k] ? SEL_W'(k) : fwd_b_sel;
      load_hit  = load_hit | ((k < LOAD_STAGE) & (match_a[k] | match_b[k]) & ld_q[k]);
    end
    stall = ~flush & load_hit;
  end

  // Next slot contents: shift toward WB; a stalled or flushed ID instruction enters as a bubble.
  always_comb begin
    v_d     = v_q;
    wr_d    = wr_q;
    ld_d    = ld_q;
    addr_d  = addr_q;
    v_d[1]    = id_valid & ~stall & ~flush;
    wr_d[1]   = id_wrt_reg;
    ld_d[1]   = id_is_load;
    addr_d[1] = id_wrt_addr;
    for (int k = 2; k <= DEPTH; k++) begin
      v_d[k]    = v_q[k-1];
      wr_d[k]   = wr_q[k-1];
      ld_d[k]   = ld_q[k-1];
      addr_d[k] = addr_q[k-1];
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      v_q         <= {DEPTH{1'b0}};
      wr_q        <= {DEPTH{1'b0}};
      ld_q        <= {DEPTH{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      for (int k = 1; k <= DEPTH; k++) begin
        addr_q[k] <= {REG_AW{1'b0}};
      end
    end else begin
      v_q         <= v_d;
      wr_q        <= wr_d;
      ld_q        <= ld_d;
      stall_cnt_q <= stall_cnt_d;
      addr_q      <= addr_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: three scoreboard configurations share one stimulus stream and are
// checked against an instruction-history reference model.
module tb_hazard_scoreboard;

  logic       clock = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs, id_uses_rt, id_wrt_reg, id_is_load, flush;
  logic [4:0] id_rs, id_rt, id_wrt_addr;

  logic        s0, s1, s2;
  logic [1:0]  fa0, fb0, fa1, fb1;
  logic [2:0]  fa2, fb2;
  logic [15:0] c0;
  logic [3:0]  c1;
  logic [7:0]  c2;

  always #5 clock = ~clock;

  hazard_scoreboard u0 (
    .clock(clock), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wrt_reg(id_wrt_reg),
    .id_wrt_addr(id_wrt_addr), .id_is_load(id_is_load), .flush(flush),
    .stall(s0), .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stall_cnt(c0));

  hazard_scoreboard #(.CNT_W(4)) u1 (
    .clock(clock), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wrt_reg(id_wrt_reg),
    .id_wrt_addr(id_wrt_addr), .id_is_load(id_is_load), .flush(flush),
    .stall(s1), .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_cnt(c1));

  hazard_scoreboard #(.DEPTH(4), .LOAD_STAGE(3), .SEL_W(3), .CNT_W(8)) u2 (
    .clock(clock), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wrt_reg(id_wrt_reg),
    .id_wrt_addr(id_wrt_addr), .id_is_load(id_is_load), .flush(flush),
    .stall(s2), .fwd_a_sel(fa2), .fwd_b_sel(fb2), .stall_cnt(c2));

  // Reference model: the last few instructions that left ID (index 1 = most recent).
  typedef struct packed { logic v; logic wr; logic [4:0] addr; logic ld; } ent_t;
  typedef struct { logic s [3]; int a [3]; int b [3]; int c [3]; } exp_t;

  ent_t hist [3][1:8];
  int   cnt  [3];
  int   dep  [3] = '{3, 3, 4};
  int   lst  [3] = '{2, 2, 3};
  int   cmax [3] = '{65535, 15, 255};

  exp_t exp_q [$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int inst, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d want=%0d at %0t", name, inst, act, want, $time);
    end
  endtask

  function automatic logic reads(input logic [4:0] src, input logic used, input ent_t e);
    return id_valid && used && src != 5'd0 && e.v && e.wr && e.addr == src;
  endfunction

  // Expected outputs of instance i from the in-flight history and the current ID inputs.
  task automatic model_out(input int i, output logic s, output int a, output int b);
    logic ha, hb;
    s = 1'b0; a = 0; b = 0;
    for (int k = 1; k <= dep[i]; k++) begin
      ha = reads(id_rs, id_uses_rs, hist[i][k]);
      hb = reads(id_rt, id_uses_rt, hist[i][k]);
      if (ha && a == 0) a = k;
      if (hb && b == 0) b = k;
      if ((ha || hb) && hist[i][k].ld && k < lst[i]) s = 1'b1;
    end
    if (flush) s = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      for (int k = 1; k <= 8; k++) hist[i][k] = '0;
    end
  endtask

  // One ID cycle: drive, predict, enqueue the prediction, then advance the model at the edge.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic wr,
                      input logic [4:0] wa, input logic ld, input logic fl);
    exp_t ne;
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_wrt_reg = wr; id_wrt_addr = wa; id_is_load = ld; flush = fl;
    for (int i = 0; i < 3; i++) begin
      model_out(i, ne.s[i], ne.a[i], ne.b[i]);
      ne.c[i] = cnt[i];
    end
    exp_q.push_back(ne);
    @(posedge clock);
    if (rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 8; k >= 2; k--) hist[i][k] = hist[i][k-1];
        hist[i][1] = '{v: v && !ne.s[i] && !fl, wr: wr, addr: wa, ld: ld};
        if (ne.s[i] && cnt[i] < cmax[i]) cnt[i]++;
      end
    end
    #1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    step(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, rd, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] rd);
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, rd, 1'b1, 1'b0);
  endtask

  // Monitor: compare every enqueued prediction against what the DUTs present.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("stall", 0, int'(s0), int'(mon_e.s[0]));
      chk("stall", 1, int'(s1), int'(mon_e.s[1]));
      chk("stall", 2, int'(s2), int'(mon_e.s[2]));
      chk("fwd_a", 0, int'(fa0), mon_e.a[0]);
      chk("fwd_a", 1, int'(fa1), mon_e.a[1]);
      chk("fwd_a", 2, int'(fa2), mon_e.a[2]);
      chk("fwd_b", 0, int'(fb0), mon_e.b[0]);
      chk("fwd_b", 1, int'(fb1), mon_e.b[1]);
      chk("fwd_b", 2, int'(fb2), mon_e.b[2]);
      chk("cnt", 0, int'(c0), mon_e.c[0]);
      chk("cnt", 1, int'(c1), mon_e.c[1]);
      chk("cnt", 2, int'(c2), mon_e.c[2]);
    end
  end

  initial begin
    int waited;
    rst = 1'b1;
    id_valid = 1'b1; id_rs = 5'($urandom); id_rt = 5'($urandom);
    id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_wrt_reg = 1'b1;
    id_wrt_addr = 5'($urandom); id_is_load = 1'b1; flush = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
      id_rs = 5'($urandom); id_rt = 5'($urandom); id_wrt_addr = id_rs;
    end
    model_clear();
    chk("rst_stall", 0, int'(s0), 0);
    chk("rst_fwd_a", 0, int'(fa0), 0);
    chk("rst_fwd_b", 0, int'(fb0), 0);
    chk("rst_cnt", 0, int'(c0), 0);
    rst = 1'b0;

    // ALU forwarding walks through slots 1..DEPTH then falls back to the register file.
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd4, 5'd3, 5'd3);
    alu(5'd11, 5'd3, 5'd0);
    alu(5'd12, 5'd3, 5'd0);
    alu(5'd13, 5'd3, 5'd0);
    alu(5'd14, 5'd3, 5'd0);

    // Load-use: one stall, then forwarded from slot 2.
    lw(5'd5);
    alu(5'd6, 5'd5, 5'd1);
    alu(5'd6, 5'd5, 5'd1);
    chk("cnt_after_load_use", 0, int'(c0), 1);

    // Register zero and unused operand never stall.
    lw(5'd0);
    alu(5'd7, 5'd0, 5'd0);
    lw(5'd8);
    step(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);

    // Flush beats stall.
    lw(5'd5);
    step(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1);
    alu(5'd20, 5'd21, 5'd22);
    chk("cnt_after_flush", 0, int'(c0), 1);

    // Saturation of the narrow counter; back-to-back loads to one register.
    for (int n = 0; n < 20; n++) begin
      lw(5'd9);
      lw(5'd9);
      alu(5'd15, 5'd9, 5'd9);
      alu(5'd15, 5'd9, 5'd9);
    end
    chk("cnt_saturated", 1, int'(c1), 15);
    chk("cnt_wide", 0, int'(c0), 21);

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0);
    end

    // Reset asserted while a load-use stall is pending.
    lw(5'd5);
    rst = 1'b1;
    alu(5'd6, 5'd5, 5'd1);
    rst = 1'b0;
    chk("cnt_mid_reset", 0, int'(c0), 0);
    alu(5'd6, 5'd5, 5'd1);
    alu(5'd6, 5'd5, 5'd1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clock);
      waited++;
    end
    chk("drain", 0, exp_q.size(), 0);
    @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard detection and forwarding-select unit for the 5-stage pipeline; replaces the fixed ern/mrn stall compare currently in CU.
- Tracks the destination of every in-flight instruction across DEPTH post-ID stages (slot 1 = EX, slot 2 = MEM, slot 3 = WB at default depth).
- Produces the load-use stall, per-operand forwarding selects and a saturating stall-cycle counter.
- Sits beside CU in ID. Its stall drives PC, IF_ID, wrt_reg_mux and ID_EX.

Parameters:
- REG_AW, 5: register address width.
- DEPTH, 3: number of tracked post-ID stages, minimum 2.
- LOAD_STAGE, 2: first slot whose load result can be forwarded. A load in slots 1..LOAD_STAGE-1 that matches a source forces a stall. Range 1..DEPTH.
- SEL_W, 2: forwarding-select width. Must satisfy 2^SEL_W > DEPTH.
- CNT_W, 16: stall counter width.

Ports:
- clock, in, 1: pipeline clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- id_valid, in, 1: ID holds a real instruction.
- id_rs, in, REG_AW: source A register address.
- id_rt, in, REG_AW: source B register address.
- id_uses_rs, in, 1: instruction reads rs.
- id_uses_rt, in, 1: instruction reads rt.
- id_wrt_reg, in, 1: instruction writes a register.
- id_wrt_addr, in, REG_AW: destination address, i.e. wrt_reg_mx.
- id_is_load, in, 1: instruction is lw.
- flush, in, 1: discard the instruction in ID.
- stall, out, 1: combinational; hold PC/IF_ID and insert a bubble into EX.
- fwd_a_sel, out, SEL_W: combinational; 0 = register file, k = result of slot k.
- fwd_b_sel, out, SEL_W: same as fwd_a_sel, for operand B.
- stall_cnt, out, CNT_W: registered count of stall cycles.

Behaviour:
- Slot state: slot[k] holds {v, wr, addr, ld} for k = 1..DEPTH.
- Reset (rst=1 at posedge): all slot fields 0, stall_cnt = 0. stall and fwd_*_sel evaluate to 0 from the first cycle after reset. rst asserted mid-stall clears everything; the pending ID instruction is not captured.
- Match rule: match_a(k) = slot[k].v & slot[k].wr & slot[k].addr==id_rs & id_rs!=0 & id_uses_rs & id_valid. match_b(k) is the same with id_rt and id_uses_rt. Register 0 never matches.
- fwd_a_sel: the smallest k with match_a(k) (youngest producer wins), else 0. fwd_b_sel is the same using match_b.
- stall = !flush & OR over k<LOAD_STAGE of ((match_a(k) | match_b(k)) & slot[k].ld).
- While stall=1, fwd selects still show the matching slot; consumers ignore them.
- Shift at every posedge when rst=0:
  - slot[k] <= slot[k-1] for k = 2..DEPTH.
  - slot[1] <= {id_valid & !stall & !flush, id_wrt_reg, id_wrt_addr, id_is_load}.
  - A bubble entry has v=0 and never matches.
- Latency: an instruction is visible in slot 1 one cycle after leaving ID and reaches slot DEPTH after DEPTH cycles. A slot[DEPTH] match covers the register-file write-then-read hazard in WB; RM needs no internal bypass.
- Flush and stall together: flush wins. stall=0 and a bubble enters slot 1.
- stall_cnt increments by 1 on each posedge sampled with stall=1. It saturates at 2^CNT_W-1 and does not wrap.
- Two consecutive loads to the same register: the younger one (slot 1) is selected and stalls once. After one bubble it sits in slot 2 and is forwarded with no further stall.
- LOAD_STAGE=1 disables load stalls entirely; it is for a memory with same-cycle read.

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1 and random inputs -> stall=0, fwd_a_sel=fwd_b_sel=0, stall_cnt=0.
- ALU forward: add $3,$1,$2, then sub $4,$3,$3 next cycle -> fwd_a_sel=fwd_b_sel=1, stall=0. One cycle later a consumer of $3 gets sel=2; one cycle after that, sel=3; then sel=0.
- Load-use: lw $5,0($0), then add $6,$5,$1 -> stall=1 for exactly one cycle with a bubble in slot 1. The next cycle shows fwd_a_sel=2, stall=0, stall_cnt=1.
- Register zero and unused operand: lw $0, then add $7,$0,$0 -> no stall, sel=0. lw $8 followed by an instruction with rt=8 but id_uses_rt=0 -> no stall.
- Flush priority: a load-use pair with flush=1 in the consumer cycle -> stall=0, slot 1 receives a bubble, stall_cnt unchanged.
- Saturation: CNT_W=4 with a repeated load-use pattern (20 stalls) -> stall_cnt reaches 15 and holds at 15.
